// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register with saturating fill count; flush wins over shift.
// Exposes next-state values so the compare can act on the bit being accepted this edge.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic                          shift,
    input  logic                          flush,
    input  logic                          x,
    output logic [PAT_W-1:0]              hist_n,
    output logic [clog2(PAT_W+1)-1:0]     fill,
    output logic [clog2(PAT_W+1)-1:0]     fill_n
);

    localparam int                FILL_W   = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0] hist;

    // Truncating the concatenation drops the oldest bit and also covers PAT_W=1.
    assign hist_n = PAT_W'({hist, x});
    assign fill_n = (fill == FILL_MAX) ? fill : fill + 1'b1;

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_n;
            fill <= fill_n;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector: registered match pulse and saturating count, one edge after the completing bit.
// in_valid qualifies each bit, no backpressure; SEQ_DET_MASK_EN adds a per-bit compare mask (pat_mask).
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic                          in_valid,
    input  logic                          x,
    input  logic [PAT_W-1:0]              pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0]              pat_mask,
`endif
    input  logic                          overlap_en,
    input  logic                          clear,
    output logic                          op,
    output logic [CNT_W-1:0]              match_cnt,
    output logic [clog2(PAT_W+1)-1:0]     fill
);

    localparam int FILL_W = clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_n;
    logic [PAT_W-1:0]  cmp_mask;
    logic [FILL_W-1:0] fill_n;
    logic              accept;
    logic              match;
    logic              flush;

`ifdef SEQ_DET_MASK_EN
    assign cmp_mask = pat_mask;
`else
    assign cmp_mask = '1;
`endif

    // A bit arriving alongside clear is dropped.
    assign accept = in_valid & ~clear;
    assign match  = accept && (fill_n == FILL_W'(PAT_W))
                    && (((hist_n ^ pattern) & cmp_mask) == '0);
    assign flush  = clear | (match & (overlap_en == MODE_NONOVL));

    seq_det_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .areset_n (areset_n),
        .shift    (accept),
        .flush    (flush),
        .x        (x),
        .hist_n   (hist_n),
        .fill     (fill),
        .fill_n   (fill_n)
    );

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            op        <= 1'b0;
            match_cnt <= '0;
        end else if (clear) begin
            op        <= 1'b0;
            match_cnt <= '0;
        end else begin
            op <= match;
            if (match && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule
